// File: rtl/fas_frame_sched.sv
// rtl/fas_frame_sched.sv - ping-pong frame scheduler between FIR output and FFT engine
module fas_frame_sched #(
  parameter int DW         = 16,
  parameter int FRAME_LEN  = 16,
  parameter int NUM_FRAMES = 64
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              fir_valid,
  input  logic [DW-1:0]                     fir_d,
  input  logic                              fft_ready,
  input  logic                              fft_valid,
  output logic                              fft_start,
  output logic                              fft_in_valid,
  output logic [DW-1:0]                     fft_in_d,
  output logic [$clog2(FRAME_LEN)-1:0]      fft_in_idx,
  output logic [$clog2(NUM_FRAMES+1)-1:0]   frame_cnt,
  output logic                              overflow,
  output logic                              done
);

  localparam int IW = $clog2(FRAME_LEN);
  localparam int CW = $clog2(NUM_FRAMES + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_LEN - 1);
  localparam logic [CW-1:0] RUN_LEN  = CW'(NUM_FRAMES);

  typedef enum logic [1:0] {IDLE, STREAM, WAIT, DONE} state_t;

  // Two banks of FRAME_LEN words, addressed as {bank, ptr}
  logic [DW-1:0] mem [0:2*FRAME_LEN-1];

  logic          wr_bank;
  logic [IW-1:0] wr_ptr;
  logic [CW-1:0] wr_frames;
  logic [1:0]    full;

  state_t        state, state_n;
  logic          rd_bank, rd_bank_n;
  logic [IW-1:0] rd_ptr, rd_ptr_n;
  logic          rd_clr;

  logic          start_n, in_valid_n, done_n;
  logic [DW-1:0] in_d_n;
  logic [IW-1:0] idx_n;
  logic [CW-1:0] cnt_n, cnt_inc;

  logic          wr_accept, wr_en, wr_last;
  logic [1:0]    full_set, full_clr;

  // Writer decodes: once the run quota is written, samples are silently ignored
  always_comb begin
    wr_accept = fir_valid && (wr_frames < RUN_LEN);
    wr_en     = wr_accept && !full[wr_bank];
    wr_last   = wr_en && (wr_ptr == LAST_IDX);
    full_set  = {wr_bank, ~wr_bank} & {2{wr_last}};
    full_clr  = {rd_bank, ~rd_bank} & {2{rd_clr}};
  end

  // Sample storage; contents need no reset
  always_ff @(posedge clk) begin
    if (wr_en) mem[{wr_bank, wr_ptr}] <= fir_d;
  end

  // Write pointer, bank select, frame quota and sticky overflow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bank   <= 1'b0;
      wr_ptr    <= '0;
      wr_frames <= '0;
      overflow  <= 1'b0;
    end else begin
      if (wr_accept && full[wr_bank]) overflow <= 1'b1;
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (wr_last) begin
          wr_ptr    <= '0;
          wr_bank   <= ~wr_bank;
          wr_frames <= wr_frames + 1'b1;
        end
      end
    end
  end

  // Bank-full flags: writer sets and reader clears always target different banks
  always_ff @(posedge clk or posedge rst) begin
    if (rst) full <= 2'b00;
    else     full <= (full & ~full_clr) | full_set;
  end

  // Read FSM next state and next registered outputs
  always_comb begin
    state_n    = state;
    rd_bank_n  = rd_bank;
    rd_ptr_n   = rd_ptr;
    rd_clr     = 1'b0;
    start_n    = 1'b0;
    in_valid_n = 1'b0;
    in_d_n     = fft_in_d;
    idx_n      = fft_in_idx;
    cnt_inc    = frame_cnt + 1'b1;
    cnt_n      = frame_cnt;
    done_n     = done;
    case (state)
      IDLE: begin
        if (full[rd_bank] && fft_ready) begin
          state_n    = STREAM;
          start_n    = 1'b1;
          in_valid_n = 1'b1;
          in_d_n     = mem[{rd_bank, {IW{1'b0}}}];
          idx_n      = '0;
          rd_ptr_n   = {{(IW-1){1'b0}}, 1'b1};
        end
      end
      STREAM: begin
        in_valid_n = 1'b1;
        in_d_n     = mem[{rd_bank, rd_ptr}];
        idx_n      = rd_ptr;
        rd_ptr_n   = rd_ptr + 1'b1;
        if (rd_ptr == LAST_IDX) begin
          rd_clr    = 1'b1;
          rd_bank_n = ~rd_bank;
          state_n   = WAIT;
        end
      end
      WAIT: begin
        if (fft_valid) begin
          cnt_n = cnt_inc;
          if (cnt_inc == RUN_LEN) begin
            state_n = DONE;
            done_n  = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: begin
        done_n = 1'b1;
      end
    endcase
  end

  // Read FSM state and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      rd_bank      <= 1'b0;
      rd_ptr       <= '0;
      fft_start    <= 1'b0;
      fft_in_valid <= 1'b0;
      fft_in_d     <= '0;
      fft_in_idx   <= '0;
      frame_cnt    <= '0;
      done         <= 1'b0;
    end else begin
      state        <= state_n;
      rd_bank      <= rd_bank_n;
      rd_ptr       <= rd_ptr_n;
      fft_start    <= start_n;
      fft_in_valid <= in_valid_n;
      fft_in_d     <= in_d_n;
      fft_in_idx   <= idx_n;
      frame_cnt    <= cnt_n;
      done         <= done_n;
    end
  end

endmodule

// File: tb/tb_fas_frame_sched.sv
// tb/tb_fas_frame_sched.sv - scoreboard bench for fas_frame_sched
module tb_fas_frame_sched;

  localparam int DW = 16;
  localparam int FL = 16;
  localparam int NF = 4;

  logic          clk, rst;
  logic          fir_valid, fft_ready, fft_valid;
  logic [DW-1:0] fir_d;
  logic          fft_start, fft_in_valid, overflow, done;
  logic [DW-1:0] fft_in_d;
  logic [3:0]    fft_in_idx;
  logic [2:0]    frame_cnt;

  typedef struct {
    logic          start;
    logic [3:0]    idx;
    logic [DW-1:0] d;
  } beat_t;

  beat_t sb[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  logic  prev_valid = 1'b0;

  fas_frame_sched #(.DW(DW), .FRAME_LEN(FL), .NUM_FRAMES(NF)) dut (
    .clk(clk), .rst(rst), .fir_valid(fir_valid), .fir_d(fir_d),
    .fft_ready(fft_ready), .fft_valid(fft_valid), .fft_start(fft_start),
    .fft_in_valid(fft_in_valid), .fft_in_d(fft_in_d), .fft_in_idx(fft_in_idx),
    .frame_cnt(frame_cnt), .overflow(overflow), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every presented beat must match the head of the scoreboard
  always @(negedge clk) begin
    beat_t e;
    if (fft_in_valid) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_beat: got d=%h idx=%0d start=%0b, expected no beat",
                 fft_in_d, fft_in_idx, fft_start);
      end else begin
        e = sb.pop_front();
        if (fft_in_d !== e.d || fft_in_idx !== e.idx || fft_start !== e.start) begin
          n_fail++;
          $display("FAIL beat: got d=%h idx=%0d start=%0b, expected d=%h idx=%0d start=%0b",
                   fft_in_d, fft_in_idx, fft_start, e.d, e.idx, e.start);
        end
      end
      if (!fft_start) begin
        n_checks++;
        if (!prev_valid) begin
          n_fail++;
          $display("FAIL burst_gap: idx=%0d arrived after an idle cycle, expected contiguous", fft_in_idx);
        end
      end
    end
    prev_valid = fft_in_valid;
  end

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input logic [DW-1:0] base);
    for (int i = 0; i < FL; i++) begin
      beat_t b;
      b.start = (i == 0);
      b.idx   = 4'(i);
      b.d     = base + DW'(i);
      sb.push_back(b);
    end
  endtask

  task automatic feed(input logic [DW-1:0] base, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      fir_valid = 1'b1;
      fir_d     = base + DW'(i);
      tick();
      fir_valid = 1'b0;
      repeat (gap) tick();
    end
  endtask

  task automatic pulse_fft_valid();
    fft_valid = 1'b1;
    tick();
    fft_valid = 1'b0;
  endtask

  task automatic wait_burst_end(input string name);
    int n;
    n = 0;
    while (!fft_in_valid && n < 60) begin tick(); n++; end
    while (fft_in_valid && n < 60) begin tick(); n++; end
    check_eq({name, "_burst_timeout"}, 32'(n >= 60), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    int n;
    rst = 1'b1; fir_valid = 1'b0; fir_d = '0; fft_ready = 1'b0; fft_valid = 1'b0;
    tick();
    tick();
    check_eq("rst_start",    32'(fft_start),    32'd0);
    check_eq("rst_in_valid", 32'(fft_in_valid), 32'd0);
    check_eq("rst_in_d",     32'(fft_in_d),     32'd0);
    check_eq("rst_in_idx",   32'(fft_in_idx),   32'd0);
    check_eq("rst_frame_cnt",32'(frame_cnt),    32'd0);
    check_eq("rst_overflow", 32'(overflow),     32'd0);
    check_eq("rst_done",     32'(done),         32'd0);
    rst = 1'b0;
    tick();

    // Single frame, with spurious fft_valid in IDLE and during STREAM
    fft_ready = 1'b1;
    pulse_fft_valid();
    check_eq("spurious_idle_cnt", 32'(frame_cnt), 32'd0);
    push_frame(16'h0001);
    feed(16'h0001, 16, 0);
    check_eq("start_not_yet", 32'(fft_start), 32'd0);
    tick();
    check_eq("start_latency", 32'(fft_start), 32'd1);
    check_eq("idx0_latency",  32'(fft_in_idx), 32'd0);
    pulse_fft_valid();
    check_eq("spurious_stream_cnt", 32'(frame_cnt), 32'd0);
    wait_burst_end("single");
    pulse_fft_valid();
    check_eq("single_cnt", 32'(frame_cnt), 32'd1);
    check_eq("single_ovf", 32'(overflow), 32'd0);

    // Backpressure and overflow
    do_reset();
    fft_ready = 1'b0;
    push_frame(16'h0100);
    push_frame(16'h0110);
    feed(16'h0100, 33, 0);
    check_eq("bp_overflow", 32'(overflow), 32'd1);
    repeat (3) tick();
    check_eq("bp_no_burst", 32'(fft_in_valid), 32'd0);
    fft_ready = 1'b1;
    wait_burst_end("bp1");
    pulse_fft_valid();
    check_eq("bp_cnt1", 32'(frame_cnt), 32'd1);
    wait_burst_end("bp2");
    pulse_fft_valid();
    check_eq("bp_cnt2", 32'(frame_cnt), 32'd2);
    check_eq("bp_overflow_sticky", 32'(overflow), 32'd1);

    // Gapped input
    do_reset();
    push_frame(16'h0001);
    feed(16'h0001, 16, 2);
    wait_burst_end("gapped");
    check_eq("gapped_ovf", 32'(overflow), 32'd0);

    // Run completion
    do_reset();
    for (int f = 0; f < NF; f++) begin
      push_frame(16'h0200 + DW'(16 * f));
      feed(16'h0200 + DW'(16 * f), 16, 0);
      wait_burst_end("run");
      repeat (2) tick();
      pulse_fft_valid();
      check_eq("run_cnt",  32'(frame_cnt), 32'(f + 1));
      check_eq("run_done", 32'(done),      32'(f == NF - 1));
    end
    feed(16'h0300, 16, 0);
    repeat (4) tick();
    check_eq("run_extra_no_burst", 32'(fft_in_valid), 32'd0);
    check_eq("run_extra_no_ovf",   32'(overflow),     32'd0);
    pulse_fft_valid();
    check_eq("run_fifth_valid_cnt", 32'(frame_cnt), 32'd4);
    check_eq("run_done_sticky",     32'(done),      32'd1);

    // Reset mid-burst
    do_reset();
    push_frame(16'h0400);
    feed(16'h0400, 16, 0);
    n = 0;
    while (!(fft_in_valid && fft_in_idx == 4'd7) && n < 40) begin tick(); n++; end
    check_eq("midrst_reach_idx7", 32'(n >= 40), 32'd0);
    rst = 1'b1;
    #1;
    check_eq("midrst_in_valid", 32'(fft_in_valid), 32'd0);
    check_eq("midrst_start",    32'(fft_start),    32'd0);
    check_eq("midrst_in_d",     32'(fft_in_d),     32'd0);
    check_eq("midrst_in_idx",   32'(fft_in_idx),   32'd0);
    sb.delete();
    tick();
    rst = 1'b0;
    tick();
    push_frame(16'h0500);
    feed(16'h0500, 16, 0);
    wait_burst_end("post_rst");
    check_eq("post_rst_cnt0", 32'(frame_cnt), 32'd0);
    pulse_fft_valid();
    check_eq("post_rst_cnt1", 32'(frame_cnt), 32'd1);

    tick();
    check_eq("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
